fft_frame_ctrl: RTL

//  Frame-level sequencer for the 32-point radix-2 FFT engine and its 2-bank working memory.

---
 rtl/fft_frame_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer for the 32-point FFT: bit-reversed load, engine kick with watchdog,
// then natural-order unload of results over a valid/ready stream.
module fft_frame_ctrl #(
  parameter int N_POINTS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              start_fft,
  input  logic              fft_done,
  output logic              mem_own,
  output logic              host_we,
  output logic [ADDR_W-1:0] host_addr,
  output logic [DATA_W-1:0] host_wdata,
  input  logic [DATA_W-1:0] host_rdata,
  output logic              busy,
  output logic              err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
  localparam logic [WD_W-1:0]   WD_LIMIT = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_KICK, S_RUN, S_RD, S_CAP, S_HOLD
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [WD_W-1:0]     wdog_q, wdog_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic                accept;

  function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] k);
    logic [ADDR_W-1:0] r;
    for (int i = 0; i < ADDR_W; i++) r[i] = k[ADDR_W-1-i];
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      wdog_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wdog_q      <= wdog_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wdog_d      = wdog_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: if (accept) begin
        cnt_d   = ADDR_W'(1);
        state_d = S_LOAD;
      end
      S_LOAD: if (accept) begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_KICK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_KICK: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      // Done has priority over the watchdog when both land on the same cycle.
      S_RUN: begin
        if (fft_done)                state_d = S_RD;
        else if (wdog_q == WD_LIMIT) state_d = S_IDLE;
        else                         wdog_d  = wdog_q + 1'b1;
      end
      S_RD: state_d = S_CAP;
      S_CAP: begin
        out_data_d  = host_rdata;
        out_valid_d = 1'b1;
        out_last_d  = (cnt_q == LAST_IDX);
        state_d     = S_HOLD;
      end
      S_HOLD: if (out_ready) begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          state_d = S_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state_q == S_IDLE) || (state_q == S_LOAD);
    accept     = in_valid && in_ready;
    host_we    = accept;
    host_wdata = accept ? in_data : '0;
    host_addr  = '0;
    if (in_ready)              host_addr = bitrev(cnt_q);
    else if (state_q == S_RD)  host_addr = cnt_q;
    start_fft  = (state_q == S_KICK);
    mem_own    = (state_q == S_KICK) || (state_q == S_RUN);
    busy       = (state_q != S_IDLE);
    err        = (state_q == S_RUN) && !fft_done && (wdog_q == WD_LIMIT);
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule
